// File: rtl/pixel_scanner_pkg.sv
// Shared types and constants for the pixel scanner and its ray-generation neighbours.
package pixel_scanner_pkg;

  localparam int PIXEL_WIDTH_DEF  = 800;
  localparam int PIXEL_HEIGHT_DEF = 600;
  localparam int SAMPLES_DEF      = 4;
  localparam int COORD_W          = 10;
  localparam int SAMPLE_W         = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pixel_coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // Width of a counter covering 0..n-1; a single-value range still needs one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_scanner_if.sv
// Scanner-to-consumer bundle: control inputs plus the coordinate beat and frame markers.
interface pixel_scanner_if;
  import pixel_scanner_pkg::*;

  logic                start;
  logic                stall;
  logic [COORD_W-1:0]  pixel_x;
  logic [COORD_W-1:0]  pixel_y;
  logic [SAMPLE_W-1:0] sample_idx;
  logic                valid;
  logic                first_sample;
  logic                last_sample;
  logic                frame_start;
  logic                frame_done;
  logic                busy;

  modport master (
    input  start, stall,
    output pixel_x, pixel_y, sample_idx, valid, first_sample, last_sample,
           frame_start, frame_done, busy
  );

  modport slave (
    output start, stall,
    input  pixel_x, pixel_y, sample_idx, valid, first_sample, last_sample,
           frame_start, frame_done, busy
  );

endinterface

// File: rtl/pixel_scanner_wrap_counter.sv
// Enabled up-counter that returns to zero after MAX; wrap flags the terminal count.
module pixel_scanner_wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // Equality against the terminal value, so non-power-of-two ranges never overflow.
  assign wrap = (count == MAX_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/pixel_scanner.sv
// Raster-order pixel/sample coordinate generator with a shared downstream stall.
module pixel_scanner
  import pixel_scanner_pkg::*;
#(
  parameter int PIXEL_WIDTH       = PIXEL_WIDTH_DEF,
  parameter int PIXEL_HEIGHT      = PIXEL_HEIGHT_DEF,
  parameter int SAMPLES_PER_PIXEL = SAMPLES_DEF,
  parameter int CONTINUOUS        = 0
) (
  input  logic            clk,
  input  logic            rst,
  pixel_scanner_if.master bus,
  output scan_state_t     dbg_state
);

  localparam int XW = cnt_w(PIXEL_WIDTH);
  localparam int YW = cnt_w(PIXEL_HEIGHT);
  localparam int SW = cnt_w(SAMPLES_PER_PIXEL);

  if (PIXEL_WIDTH < 1 || PIXEL_WIDTH > 1024 ||
      PIXEL_HEIGHT < 1 || PIXEL_HEIGHT > 1024 ||
      SAMPLES_PER_PIXEL < 1 || SAMPLES_PER_PIXEL > 256 ||
      CONTINUOUS < 0 || CONTINUOUS > 1) begin : g_param_check
    $fatal(1, "pixel_scanner: parameter out of range");
  end

  scan_state_t   state;
  logic          valid_q;
  logic          frame_start_q;
  logic          frame_done_q;
  logic          busy_q;
  logic          accept;
  logic          cnt_clr;
  logic          x_en;
  logic          y_en;
  logic          last_beat;
  logic          s_wrap;
  logic          x_wrap;
  logic          y_wrap;
  logic [SW-1:0] s_cnt;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  pixel_coord_t  coord;

  // Handshake: a beat is taken on any clk edge with valid && !stall. While stall
  // is high every output holds, and the counters move only on an accepted beat.
  assign accept    = valid_q && !bus.stall;
  assign x_en      = accept && s_wrap;
  assign y_en      = x_en && x_wrap;
  assign last_beat = y_en && y_wrap;
  assign cnt_clr   = (state != SCAN);

  pixel_scanner_wrap_counter #(.MAX(SAMPLES_PER_PIXEL - 1), .W(SW)) u_sample_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (accept),
    .count (s_cnt),
    .wrap  (s_wrap)
  );

  pixel_scanner_wrap_counter #(.MAX(PIXEL_WIDTH - 1), .W(XW)) u_x_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (x_en),
    .count (x_cnt),
    .wrap  (x_wrap)
  );

  pixel_scanner_wrap_counter #(.MAX(PIXEL_HEIGHT - 1), .W(YW)) u_y_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (y_en),
    .count (y_cnt),
    .wrap  (y_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done_q <= 1'b0;
          if (bus.start) begin
            state         <= SCAN;
            valid_q       <= 1'b1;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        SCAN: begin
          if (accept) begin
            frame_start_q <= 1'b0;
            if (last_beat) begin
              state        <= DONE;
              valid_q      <= 1'b0;
              frame_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // Single-cycle state regardless of stall; start arriving here is dropped.
          frame_done_q <= 1'b0;
          if (CONTINUOUS != 0) begin
            state         <= SCAN;
            valid_q       <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          valid_q       <= 1'b0;
          frame_start_q <= 1'b0;
          frame_done_q  <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign coord.x = COORD_W'(x_cnt);
  assign coord.y = COORD_W'(y_cnt);

  assign bus.pixel_x      = coord.x;
  assign bus.pixel_y      = coord.y;
  assign bus.sample_idx   = SAMPLE_W'(s_cnt);
  assign bus.valid        = valid_q;
  assign bus.first_sample = valid_q && (s_cnt == '0);
  assign bus.last_sample  = valid_q && s_wrap;
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = busy_q;
  assign dbg_state        = state;

endmodule

// File: doc/pixel_scanner.md
Name: pixel_scanner

Overview:
- Upstream neighbour of generate_ray.
- Walks the sensor in raster order and emits one pixel coordinate per accepted cycle on pixel_x/pixel_y. Each pixel is repeated SAMPLES_PER_PIXEL times, so the ray generator's jitter produces supersamples.
- Honours the same stall signal that freezes generate_ray, so coordinates and downstream pipeline stay aligned.
- Reports frame start, per-pixel first/last sample and frame completion to the frame accumulator.

Parameters:
- PIXEL_WIDTH, 800, horizontal resolution; legal range 1..1024.
- PIXEL_HEIGHT, 600, vertical resolution; legal range 1..1024.
- SAMPLES_PER_PIXEL, 4, coordinate repeats per pixel; legal range 1..256.
- CONTINUOUS, 0:
  - 1 = restart the next frame automatically after frame_done.
  - 0 = wait for start.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- stall  in  1  downstream hold; shared with generate_ray
- pixel_x  out  10  current pixel column
- pixel_y  out  10  current pixel row
- sample_idx  out  8  sample number within current pixel
- valid  out  1  pixel_x/pixel_y/sample_idx are live
- first_sample  out  1  valid && sample_idx==0
- last_sample  out  1  valid && sample_idx==SAMPLES_PER_PIXEL-1
- frame_start  out  1  high with the (0,0,0) beat of a frame
- frame_done  out  1  one-cycle pulse after the final beat is accepted
- busy  out  1  state != IDLE

Behaviour:
- Reset: every output is 0, and the state is IDLE. Reset mid-frame abandons the frame immediately, and no frame_done is produced.
- Handshake: a beat is accepted on a clk edge where valid && !stall.
  - While stall=1, all outputs hold their values exactly, including frame_start and last_sample.
  - Counters advance only on accept.
- States:
  - IDLE: valid=0. start=1 moves to SCAN next cycle with x=0, y=0, s=0, valid=1, frame_start=1. Latency from start to first valid is 1 cycle.
  - SCAN: on each accept, s increments.
    - When s==S-1, s wraps to 0 and x increments.
    - When x==W-1, x wraps to 0 and y increments.
    - frame_start clears after the first accept.
    - Acceptance of the beat (W-1, H-1, S-1) moves the state to DONE.
  - DONE: lasts one cycle, with valid=0 and frame_done=1.
    - If CONTINUOUS=1, the next state is SCAN starting at (0,0,0) with frame_start=1.
    - Otherwise the next state is IDLE.
    - stall does not extend DONE.
- start while in SCAN or DONE is ignored. It is not queued.
- start and stall high together in IDLE: the scanner enters SCAN anyway. The first beat is then held until stall drops.
- Degenerate sizes:
  - W=1 and/or H=1 wrap correctly.
  - With S=1, first_sample and last_sample are both high on every beat.
  - A 1x1x1 frame is one beat followed by DONE.
- Width rules:
  - Internal counters are $clog2-sized. Outputs are zero-extended to 10 and 8 bits.
  - The wrap compare is equality against parameter-1, never overflow.
- Per-frame totals: a frame emits exactly W*H*S accepted beats. pixel_x never reaches W and pixel_y never reaches H.
- Elaboration check: $fatal on any out-of-range parameter.

Decomposition:
- Shared package (alongside ray types):
  - PIXEL_WIDTH/PIXEL_HEIGHT defaults
  - coordinate width constant COORD_W=10
  - typedef pixel_coord_t {logic [9:0] x; logic [9:0] y;}
  - scan_state_t enum {IDLE, SCAN, DONE}
- One natural sub-module: wrap_counter, a parameterised counter with an enable, a max value, and a wrap output. It is instantiated three times, chained by the wrap-and-enable signals for sample, x and y.

Test Plan:
- Params W=4, H=3, S=2, stall=0; pulse start.
  - Expect 24 consecutive beats with sequence (0,0,0),(0,0,1),(1,0,0)…(3,2,1).
  - frame_start only on beat 0.
  - frame_done exactly 1 cycle after beat 24, then valid=0 and busy=0.
- Same params; assert stall on beats 5–7 and randomly at 30% density thereafter.
  - Outputs are frozen across every stalled cycle.
  - The accepted sequence is identical to the no-stall case, still 24 beats.
- Assert rst at beat 10 for 2 cycles, then pulse start.
  - Outputs go to 0 asynchronously, and no frame_done occurs.
  - The new frame begins at (0,0,0) with frame_start=1.
- Pulse start during SCAN, and with start held high during DONE (CONTINUOUS=0).
  - The frame is unaffected.
  - After DONE the scanner returns to IDLE; a fresh start is then needed for a new frame.
- CONTINUOUS=1, W=2, H=1, S=1:
  - beats (0,0),(1,0), then frame_done, then (0,0) with frame_start=1 on the following cycle.
  - Repeats for 3 frames.
- Default params, chained into generate_ray with shared stall:
  - The ray direction for each beat matches the real-valued model within 0.01.
  - Exactly 1,920,000 beats per frame.
